mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Sequences and shares the single main-memory port (memory4c: pipelined, fixed read latency, data_valid strobe)
//  between the I-cache fill FSM, the D-cache fill FSM and D-side write-through stores.
//  Issues the 8 word reads of a block fill back-to-back and routes returning beats to the owner.
//  Sits between both cache_fill_FSM instances and mainMemory inside the cache access level.
// PARAMETERS
//  MEM_LAT  4   cycles from mem_en (read) to mem_valid; used only for the drain check
//  BEATS    8   16-bit words per cache block; block = 16 bytes; beat address step = 2
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  i_req        in   1   I-cache miss: fill request, level, held until i_done
//  i_addr       in   16  I-side miss address; [3:0] ignored
//  i_grant      out  1   I side owns memory port (FILL_I state)
//  i_valid      out  1   returned beat on mem_rdata belongs to I side
//  i_beat       out  3   word index of current I beat (drives I-cache wordEn)
//  i_done       out  1   1-cycle pulse: last I beat delivered
//  d_req        in   1   D-cache miss: fill request, level, held until d_done
//  d_we         in   1   D-side write-through store request, level, held until d_done
//  d_addr       in   16  D-side address (block for fill, word for store)
//  d_wdata      in   16  store data
//  d_grant      out  1   D side owns memory port (FILL_D or WRITE)
//  d_valid      out  1   returned beat belongs to D side
//  d_beat       out  3   word index of current D beat
//  d_done       out  1   1-cycle pulse: last D beat delivered or store issued
//  mem_en       out  1   memory enable
//  mem_wr       out  1   memory write (only with mem_en)
//  mem_addr     out  16  memory address
//  mem_wdata    out  16  memory write data
//  mem_valid    in   1   memory data_valid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; last_owner = D (so I wins first tie).
//  States: IDLE, FILL_I, FILL_D, WRITE.
//  IDLE: pick requester; d_we before d_req (store then fill if both); D vs I tie -> side not in last_owner;
//   single requester wins immediately. Transition takes effect next cycle; no output strobes in IDLE.
//  FILL_x: mem_en=1, mem_wr=0 on cycles issue_cnt=0..BEATS-1, mem_addr={addr[15:4], issue_cnt, 1'b0};
//   base address latched on entry, later addr changes ignored. Each mem_valid: x_valid=1,
//   x_beat=rcv_cnt, rcv_cnt++. On rcv_cnt==BEATS-1 with mem_valid: x_done=1, last_owner=x, -> IDLE.
//   Fill latency: grant cycle + MEM_LAT + BEATS-1 cycles to x_done.
//  WRITE: one cycle, mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1, -> IDLE.
//  No preemption: request drop or new request mid-fill ignored until fill completes.
//  mem_valid in IDLE/WRITE ignored (no x_valid). Grants are mutually exclusive, never both 1.
//  Counters 3/4-bit, no wrap past BEATS; issue stops at BEATS.
//  Async reset mid-fill: immediate IDLE, outputs 0; late mem_valid beats after reset dropped.
// TESTING
//  i_req=1,i_addr=0x1234 alone -> mem_addr 0x1230..0x123E consecutive, i_valid x8 beats 0..7, i_done once.
//  d_we=1,d_addr=0x0042,d_wdata=0xBEEF -> 1 cycle mem_en=mem_wr=1, addr 0x0042, data 0xBEEF, d_done.
//  i_req & d_req same cycle after reset -> I filled first, then D; repeat tie -> D first.
//  d_we & d_req together -> WRITE cycle, then FILL_D; i_req arriving mid-fill waits, no i_valid.
//  rst_n low at beat 3 of FILL_D -> outputs 0 same cycle; remaining mem_valid produce no d_valid.
//  Drop i_req mid-FILL_I -> fill still completes with 8 beats and i_done.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single pipelined main-memory port between the I-cache fill,
// the D-cache fill and D-side write-through stores. Block fills issue all
// beat reads back-to-back and route returning beats to the owning side.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned BEATS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_valid,
  output logic [2:0]  i_beat,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_valid,
  output logic [2:0]  d_beat,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_valid
);

  localparam int unsigned AW    = 16;
  localparam int unsigned TAG_W = AW - 4;
  localparam int unsigned BW    = 3;
  localparam int unsigned CW    = 4;

  // Beat counters and address packing are sized for 8-word blocks; the
  // memory must return the first beat before the last read is issued.
  if (BEATS != 8 || MEM_LAT == 0 || MEM_LAT >= BEATS) begin : g_bad_param
    $error("mem_port_arbiter: unsupported BEATS/MEM_LAT combination");
  end

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t           state, state_nxt;
  logic             last_d, last_d_nxt;   // 1: D side completed the last fill
  logic [TAG_W-1:0] base, base_nxt;       // latched block address of the fill
  logic [CW-1:0]    issue_cnt, issue_nxt; // reads issued in this fill
  logic [BW-1:0]    rcv_cnt, rcv_nxt;     // beats received in this fill
  logic             d_any;
  logic             fill_d;
  logic             unused;

  assign d_any  = d_we | d_req;
  assign fill_d = (state == FILL_D);
  assign unused = ^i_addr[3:0];

  // State and fill bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      base      <= '0;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      base      <= base_nxt;
      issue_cnt <= issue_nxt;
      rcv_cnt   <= rcv_nxt;
    end
  end

  // Arbitration, read issue, beat routing and memory-port drive.
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    base_nxt   = base;
    issue_nxt  = issue_cnt;
    rcv_nxt    = rcv_cnt;
    i_grant    = 1'b0;
    i_valid    = 1'b0;
    i_beat     = '0;
    i_done     = 1'b0;
    d_grant    = 1'b0;
    d_valid    = 1'b0;
    d_beat     = '0;
    d_done     = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state)
      IDLE: begin
        issue_nxt = '0;
        rcv_nxt   = '0;
        if (i_req && (!d_any || last_d)) begin
          state_nxt = FILL_I;
          base_nxt  = i_addr[AW-1:4];
        end else if (d_we) begin
          state_nxt = WRITE;
        end else if (d_req) begin
          state_nxt = FILL_D;
          base_nxt  = d_addr[AW-1:4];
        end
      end

      FILL_I, FILL_D: begin
        i_grant = !fill_d;
        d_grant = fill_d;
        if (issue_cnt < CW'(BEATS)) begin
          mem_en    = 1'b1;
          mem_addr  = {base, issue_cnt[BW-1:0], 1'b0};
          issue_nxt = issue_cnt + CW'(1);
        end
        if (mem_valid) begin
          i_valid = !fill_d;
          d_valid = fill_d;
          i_beat  = fill_d ? '0 : rcv_cnt;
          d_beat  = fill_d ? rcv_cnt : '0;
          if (rcv_cnt == BW'(BEATS - 1)) begin
            i_done     = !fill_d;
            d_done     = fill_d;
            last_d_nxt = fill_d;
            state_nxt  = IDLE;
          end else begin
            rcv_nxt = rcv_cnt + BW'(1);
          end
        end
      end

      WRITE: begin
        d_grant   = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
